multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-style datapath. Outputs decode from the
// state register; the only exceptions are pcEn (gated by zero) and the DECODE illegal-opcode pulse.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opc,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       pcEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSrc,
    output logic [1:0] MemToReg,
    output logic [1:0] RegDst,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [3:0] o_state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JR    = 6'b000110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_REX    = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_SLTIEX = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;
    localparam logic [3:0] S_BEQ    = 4'd12;
    localparam logic [3:0] S_JMP    = 4'd13;
    localparam logic [3:0] S_JAL    = 4'd14;
    localparam logic [3:0] S_JR     = 4'd15;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_opc_legal;

    always_comb begin
        case (opc)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
            OP_J, OP_JAL, OP_JR, OP_SLTI: w_opc_legal = 1'b1;
            default:                      w_opc_legal = 1'b0;
        endcase
    end

    // opc is only looked at in DECODE and MEMADR; every other state ignores it.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_IDLE:   w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_REX;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_SLTI:      w_next_state = S_SLTIEX;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_J:         w_next_state = S_JMP;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_JR:        w_next_state = S_JR;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_REX:    w_next_state = S_RWB;
            S_ADDIEX: w_next_state = S_IWB;
            S_SLTIEX: w_next_state = S_IWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        PCSrc       = 2'b00;
        MemToReg    = 2'b00;
        RegDst      = 2'b00;
        instrDone   = 1'b0;
        illegalOp   = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BEQ can finish in one cycle.
                ALUSrcB = 2'b11;
                if (!w_opc_legal) begin
                    illegalOp = 1'b1;
                    instrDone = 1'b1;
                end
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemToReg  = 2'b01;
                RegWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
            end
            S_RWB: begin
                RegDst    = 2'b01;
                RegWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_SLTIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = 2'b11;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSrc       = 2'b01;
                instrDone   = 1'b1;
            end
            S_JMP: begin
                PCWrite   = 1'b1;
                PCSrc     = 2'b10;
                instrDone = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, which is the link value for r31.
                PCWrite   = 1'b1;
                PCSrc     = 2'b10;
                RegDst    = 2'b10;
                MemToReg  = 2'b10;
                RegWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_JR: begin
                PCWrite   = 1'b1;
                PCSrc     = 2'b11;
                instrDone = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pcEn    = PCWrite | (PCWriteCond & zero);
    assign o_state = r_state;

endmodule
